note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_pkg.sv | 34 +++
 rtl/seq_pattern_ram.sv | 49 ++++
 rtl/note_sequencer.sv | 161 ++++++++++++++++
 tb/tb_note_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
// Shared audio definitions for the step sequencer: FSM state encoding, the
// pattern-entry record stored per step, the MIDI note ceiling and a helper
// that applies a signed transpose with clamping to the MIDI range.
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

  localparam int MIDI_NOTE_MAX = 127;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       rest;
    logic [6:0] note;
  } pattern_entry_t;

  // Adds a signed offset to a note and saturates at 0 and MIDI_NOTE_MAX.
  function automatic logic [6:0] clamp_note(input logic [6:0]        base,
                                            input logic signed [6:0] offset);
    logic signed [8:0] sum;
    sum = $signed({2'b00, base}) + $signed({{2{offset[6]}}, offset});
    if (sum < 9'sd0)
      return 7'd0;
    else if (sum > $signed(9'(MIDI_NOTE_MAX)))
      return 7'(MIDI_NOTE_MAX);
    else
      return sum[6:0];
  endfunction

endpackage

// File: rtl/seq_pattern_ram.sv
// -----------------------------------------------------------------------------
// seq_pattern_ram
// Pattern memory: DEPTH entries of {rest, note}, one synchronous write port
// and one synchronous (registered) read port. A read of the entry being
// written in the same cycle returns the previous contents.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset (read register only)
//   wr_en     write strobe
//   wr_addr   write address
//   wr_entry  entry to store
//   rd_addr   read address, sampled every clock
//   rd_entry  registered read data
// -----------------------------------------------------------------------------
module seq_pattern_ram
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pattern_entry_t    wr_entry,
  input  logic [ADDR_W-1:0] rd_addr,
  output pattern_entry_t    rd_entry
);

  pattern_entry_t mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM primitives;
  // only the read-data register below is reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_entry;
  end

  // NOTE: non-blocking assignment on both the write and the read means a
  // same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_entry <= '0;
    else
      rd_entry <= mem[rd_addr];
  end

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Step sequencer driving a monophonic voice. Plays a pattern of STEPS
// {rest, note} entries at tempo_div sample ticks per step, wrapping after
// last_step, and produces a gate that always falls on the final tick of a
// step so the envelope retriggers on consecutive notes.
//
// Optional feature (macro NOTE_SEQUENCER_TRANSPOSE_EN): adds a signed 7-bit
// transpose input; the note output becomes stored note + transpose, clamped
// to 0..127 and sampled at each step boundary.
//
// Ports:
//   sample_clock  clock, one tick per audio sample
//   rst           asynchronous active-high reset
//   run           1 = play, 0 = stop
//   tempo_div     sample ticks per step (0 behaves as 1)
//   gate_len      sample ticks the gate is high per step
//   last_step     index of the final step before wrapping
//   wr_en/wr_addr/wr_note/wr_rest  pattern write port
//   transpose     signed semitone offset (transpose build only)
//   note          current note
//   gate          current gate
//   step          index of the step now playing
//   step_pulse    one-cycle strobe on each step start
// -----------------------------------------------------------------------------
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int STEPS  = 16,
  parameter int STEP_W = 4
) (
  input  logic              sample_clock,
  input  logic              rst,
  input  logic              run,
  input  logic [15:0]       tempo_div,
  input  logic [15:0]       gate_len,
  input  logic [STEP_W-1:0] last_step,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [6:0]        wr_note,
  input  logic              wr_rest,
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
  input  logic signed [6:0] transpose,
`endif
  output logic [6:0]        note,
  output logic              gate,
  output logic [STEP_W-1:0] step,
  output logic              step_pulse
);

  seq_state_t        state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [15:0]       div_q, div_nxt;
  logic [15:0]       eff_div, div_m1, gate_lim;
  logic [STEP_W-1:0] step_nxt, rd_addr;
  logic              advance, last_tick;
  logic              rest_q, rest_nxt, gate_nxt;
  logic [6:0]        note_nxt;
  pattern_entry_t    rd_entry;

  // Successor of a step; anything at or beyond last_step wraps to 0, which
  // also covers last_step being lowered below the step now playing.
  function automatic logic [STEP_W-1:0] next_index(input logic [STEP_W-1:0] s,
                                                   input logic [STEP_W-1:0] last);
    return (s >= last) ? '0 : s + 1'b1;
  endfunction

  assign eff_div   = (tempo_div == 16'd0) ? 16'd1 : tempo_div;
  assign last_tick = (cnt == div_q - 16'd1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    cnt_nxt   = cnt;
    div_nxt   = div_q;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_PLAY;
          step_nxt  = '0;
          cnt_nxt   = 16'd0;
          div_nxt   = eff_div;
          advance   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (!run) begin
          state_nxt = ST_IDLE;
          step_nxt  = '0;
          cnt_nxt   = 16'd0;
        end else if (last_tick) begin
          step_nxt  = next_index(step, last_step);
          cnt_nxt   = 16'd0;
          div_nxt   = eff_div;
          advance   = 1'b1;
        end else begin
          cnt_nxt   = cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The read port is synchronous, so it always fetches the successor of
    // the step about to be current; that entry is then ready in rd_entry at
    // the edge that advances into it. Idle prefetches entry 0 for the start.
    rd_addr = (state_nxt == ST_IDLE) ? '0 : next_index(step_nxt, last_step);

    rest_nxt = advance ? rd_entry.rest : rest_q;

    // Gate window is capped at eff_div-1 so the last tick of a step is low.
    div_m1   = div_nxt - 16'd1;
    gate_lim = (gate_len < div_m1) ? gate_len : div_m1;
    gate_nxt = (state_nxt == ST_PLAY) && !rest_nxt && (cnt_nxt < gate_lim);

`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
    note_nxt = clamp_note(rd_entry.note, transpose);
`else
    note_nxt = rd_entry.note;
`endif
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 16'd0;
      div_q      <= 16'd1;
      step       <= '0;
      rest_q     <= 1'b0;
      note       <= 7'd0;
      gate       <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_q      <= div_nxt;
      step       <= step_nxt;
      rest_q     <= rest_nxt;
      gate       <= gate_nxt;
      step_pulse <= advance;
      if (advance)
        note <= note_nxt;
    end
  end

  seq_pattern_ram #(
    .DEPTH  (STEPS),
    .ADDR_W (STEP_W)
  ) u_pattern_ram (
    .clk      (sample_clock),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_entry ('{rest: wr_rest, note: wr_note}),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Directed testbench for note_sequencer. Each task drives one scenario and
// compares outputs against hand-derived expectations one time unit after the
// active clock edge.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  logic        sample_clock;
  logic        rst;
  logic        run;
  logic [15:0] tempo_div;
  logic [15:0] gate_len;
  logic [3:0]  last_step;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [6:0]  wr_note;
  logic        wr_rest;
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
  logic signed [6:0] transpose;
`endif
  logic [6:0]  note;
  logic        gate;
  logic [3:0]  step;
  logic        step_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int notes [4] = '{60, 62, 64, 65};

  note_sequencer #(.STEPS(16), .STEP_W(4)) dut (
    .sample_clock (sample_clock),
    .rst          (rst),
    .run          (run),
    .tempo_div    (tempo_div),
    .gate_len     (gate_len),
    .last_step    (last_step),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_note      (wr_note),
    .wr_rest      (wr_rest),
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
    .transpose    (transpose),
`endif
    .note         (note),
    .gate         (gate),
    .step         (step),
    .step_pulse   (step_pulse)
  );

  initial sample_clock = 1'b0;
  always #5 sample_clock = ~sample_clock;

  task automatic tick();
    @(posedge sample_clock);
    #1;
  endtask

  task automatic write_entry(input int a, input int n, input bit r);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_note = 7'(n);
    wr_rest = r;
    tick();
    wr_en   = 1'b0;
  endtask

  // Leave PLAY and let the idle prefetch of entry 0 settle.
  task automatic stop_run();
    run = 1'b0;
    tick();
    tick();
  endtask

  // After this the DUT sits at step 0, tick 0 (c = 0).
  task automatic start_run();
    run = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; tempo_div = 16'd4; gate_len = 16'd2;
    last_step = 4'd3; wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_rest = 1'b0;
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
    transpose = '0;
`endif
    tick();
    tick();
    n_checks++;
    if ({note, gate, step, step_pulse} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_held: note=%0d gate=%0b step=%0d pulse=%0b, expected all 0",
               note, gate, step, step_pulse);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({note, gate, step, step_pulse} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_release: note=%0d gate=%0b step=%0d pulse=%0b, expected all 0",
               note, gate, step, step_pulse);
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 4; i++) write_entry(i, notes[i], 1'b0);
    tick();
  endtask

  task automatic test_basic_pattern();
    logic [6:0] e_note; logic e_gate; logic [3:0] e_step; logic e_pulse;
    tempo_div = 16'd4; gate_len = 16'd2; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      e_step  = 4'((c / 4) % 4);
      e_note  = 7'(notes[e_step]);
      e_gate  = (c % 4) < 2;
      e_pulse = (c % 4) == 0;
      n_checks++;
      if ({note, gate, step, step_pulse} !== {e_note, e_gate, e_step, e_pulse}) begin
        n_fail++;
        $display("FAIL basic c=%0d: note=%0d gate=%0b step=%0d pulse=%0b, expected %0d %0b %0d %0b",
                 c, note, gate, step, step_pulse, e_note, e_gate, e_step, e_pulse);
      end
    end
    stop_run();
  endtask

  task automatic test_gate_gap();
    logic e_gate; logic [3:0] e_step;
    tempo_div = 16'd4; gate_len = 16'd10; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      e_step = 4'(c / 4);
      e_gate = (c % 4) < 3;
      n_checks++;
      if ({gate, step} !== {e_gate, e_step}) begin
        n_fail++;
        $display("FAIL gate_gap c=%0d: gate=%0b step=%0d, expected %0b %0d",
                 c, gate, step, e_gate, e_step);
      end
    end
    stop_run();
  endtask

  task automatic test_rest();
    logic [6:0] e_note; logic e_gate; logic [3:0] e_step;
    write_entry(1, 70, 1'b1);
    tick();
    tempo_div = 16'd4; gate_len = 16'd2; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      e_step = 4'(c / 4);
      e_note = (e_step == 4'd1) ? 7'd70 : 7'(notes[e_step]);
      e_gate = (e_step != 4'd1) && ((c % 4) < 2);
      n_checks++;
      if ({note, gate, step} !== {e_note, e_gate, e_step}) begin
        n_fail++;
        $display("FAIL rest_step c=%0d: note=%0d gate=%0b step=%0d, expected %0d %0b %0d",
                 c, note, gate, step, e_note, e_gate, e_step);
      end
    end
    stop_run();
    write_entry(1, 62, 1'b0);
    tick();
  endtask

  task automatic test_run_stop();
    tempo_div = 16'd4; gate_len = 16'd2; last_step = 4'd3;
    start_run();
    for (int c = 1; c <= 9; c++) tick();
    n_checks++;
    if ({note, gate, step} !== {7'd64, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL run_mid_step2: note=%0d gate=%0b step=%0d, expected 64 1 2", note, gate, step);
    end
    run = 1'b0;
    tick();
    n_checks++;
    if ({note, gate, step, step_pulse} !== {7'd64, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL run_drop: note=%0d gate=%0b step=%0d pulse=%0b, expected 64 0 0 0",
               note, gate, step, step_pulse);
    end
    run = 1'b1;
    tick();
    n_checks++;
    if ({note, gate, step, step_pulse} !== {7'd60, 1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL run_restart: note=%0d gate=%0b step=%0d pulse=%0b, expected 60 1 0 1",
               note, gate, step, step_pulse);
    end
  endtask

  // Entered while playing at step 0, tick 0.
  task automatic test_async_reset();
    tick();
    n_checks++;
    if (gate !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_gate: gate=%0b, expected 1", gate);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({note, gate, step, step_pulse} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset: note=%0d gate=%0b step=%0d pulse=%0b, expected all 0",
               note, gate, step, step_pulse);
    end
    run = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({note, gate, step, step_pulse} !== 13'd0) begin
      n_fail++;
      $display("FAIL after_reset: note=%0d gate=%0b step=%0d pulse=%0b, expected all 0",
               note, gate, step, step_pulse);
    end
  endtask

  task automatic test_min_tempo();
    logic [3:0] e_step;
    tempo_div = 16'd0; gate_len = 16'd5; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      e_step = 4'(c % 4);
      n_checks++;
      if ({note, gate, step, step_pulse} !== {7'(notes[e_step]), 1'b0, e_step, 1'b1}) begin
        n_fail++;
        $display("FAIL min_tempo c=%0d: note=%0d gate=%0b step=%0d pulse=%0b, expected %0d 0 %0d 1",
                 c, note, gate, step, step_pulse, notes[e_step], e_step);
      end
    end
    stop_run();
  endtask

  task automatic test_zero_gate();
    logic [3:0] e_step; logic e_pulse;
    tempo_div = 16'd4; gate_len = 16'd0; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      e_step  = 4'(c / 4);
      e_pulse = (c % 4) == 0;
      n_checks++;
      if ({gate, step, step_pulse} !== {1'b0, e_step, e_pulse}) begin
        n_fail++;
        $display("FAIL zero_gate c=%0d: gate=%0b step=%0d pulse=%0b, expected 0 %0d %0b",
                 c, gate, step, step_pulse, e_step, e_pulse);
      end
    end
    stop_run();
  endtask

  task automatic test_last_step_change();
    int seq [6] = '{0, 1, 2, 0, 1, 0};
    logic [3:0] e_step;
    tempo_div = 16'd4; gate_len = 16'd2; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      e_step = 4'(seq[c / 4]);
      n_checks++;
      if ({note, step} !== {7'(notes[e_step]), e_step}) begin
        n_fail++;
        $display("FAIL last_step_change c=%0d: note=%0d step=%0d, expected %0d %0d",
                 c, note, step, notes[e_step], e_step);
      end
      if (c == 9) last_step = 4'd1;
    end
    stop_run();
    last_step = 4'd3;
  endtask

  task automatic test_write_current();
    logic [6:0] e_note; logic [3:0] e_step;
    tempo_div = 16'd4; gate_len = 16'd2; last_step = 4'd3;
    start_run();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      if (c == 2) wr_en = 1'b0;
      e_step = 4'((c / 4) % 4);
      e_note = (e_step == 4'd0 && c >= 16) ? 7'd48 : 7'(notes[e_step]);
      n_checks++;
      if ({note, step} !== {e_note, e_step}) begin
        n_fail++;
        $display("FAIL write_current c=%0d: note=%0d step=%0d, expected %0d %0d",
                 c, note, step, e_note, e_step);
      end
      if (c == 1) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_note = 7'd48; wr_rest = 1'b0;
      end
    end
    stop_run();
    write_entry(0, 60, 1'b0);
    tick();
  endtask

`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
  task automatic test_transpose();
    write_entry(0, 120, 1'b0);
    write_entry(1, 5, 1'b0);
    tick();
    tempo_div = 16'd4; gate_len = 16'd2; last_step = 4'd3;
    transpose = 7'sd12;
    start_run();
    n_checks++;
    if (note !== 7'd127) begin
      n_fail++;
      $display("FAIL transpose_high: note=%0d, expected 127", note);
    end
    transpose = -7'sd12;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++;
    if (note !== 7'd0) begin
      n_fail++;
      $display("FAIL transpose_low: note=%0d, expected 0", note);
    end
    stop_run();
  endtask
`endif

  initial begin
    test_reset();
    load_pattern();
    test_basic_pattern();
    test_gate_gap();
    test_rest();
    test_run_stop();
    test_async_reset();
    test_min_tempo();
    test_zero_gate();
    test_last_step_change();
    test_write_current();
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
    test_transpose();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
